// File: rtl/not_not_round_ctrl.sv
// Round/lives/score controller for the "not not" colour puzzle game.
// Optional feature macro NOT_NOT_SPEEDUP_EN: the answer window shrinks as the score grows.
module not_not_round_ctrl #(
  parameter int ROUND_TICKS = 200,
  parameter int SHOW_TICKS  = 50,
  parameter int START_LIVES = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       tick,
  input  logic       answer_valid,
  input  logic [3:0] answer,
  input  logic [3:0] expected,
  output logic       lfsr_enable,
  output logic       round_active,
  output logic [7:0] time_left,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       result_ok,
  output logic       result_bad,
  output logic       game_over
);

  localparam logic [1:0] START_L = 2'(START_LIVES);
  localparam logic [7:0] SHOW_L  = 8'(SHOW_TICKS);

  typedef enum logic [2:0] {IDLE, DRAW, PLAY, JUDGE, SHOW, OVER} state_t;

  state_t     state, state_nx;
  logic [7:0] time_left_nx, score_nx, show_cnt, show_cnt_nx, window;
  logic [1:0] lives_nx;
  logic       ok_nx, bad_nx, over_nx, timeout, timeout_nx;
  logic [3:0] captured, captured_nx;

`ifdef NOT_NOT_SPEEDUP_EN
  localparam logic [10:0] RT_W    = 11'(ROUND_TICKS);
  localparam logic [10:0] FLOOR_W = 11'(ROUND_TICKS / 4);
  logic [10:0] penalty;

  // Window = max(ROUND_TICKS - 4*score, ROUND_TICKS/4), kept wide so 4*score cannot wrap.
  always_comb begin
    penalty = {1'b0, score, 2'b00};
    if (penalty + FLOOR_W < RT_W) window = 8'(RT_W - penalty);
    else                          window = 8'(FLOOR_W);
  end
`else
  assign window = 8'(ROUND_TICKS);
`endif

  always_comb begin
    state_nx     = state;
    time_left_nx = time_left;
    score_nx     = score;
    lives_nx     = lives;
    ok_nx        = result_ok;
    bad_nx       = result_bad;
    over_nx      = game_over;
    captured_nx  = captured;
    timeout_nx   = timeout;
    show_cnt_nx  = show_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          score_nx = 8'd0;
          lives_nx = START_L;
          state_nx = DRAW;
        end
      end
      DRAW: begin
        time_left_nx = window;
        timeout_nx   = 1'b0;
        state_nx     = PLAY;
      end
      PLAY: begin
        // A submit in the same cycle as the final tick beats the timeout.
        if (answer_valid) begin
          captured_nx = answer;
          state_nx    = JUDGE;
        end else if (tick) begin
          if (time_left <= 8'd1) begin
            time_left_nx = 8'd0;
            timeout_nx   = 1'b1;
            state_nx     = JUDGE;
          end else begin
            time_left_nx = time_left - 8'd1;
          end
        end
      end
      JUDGE: begin
        if (!timeout && captured == expected) begin
          if (score != 8'hFF) score_nx = score + 8'd1;
          ok_nx = 1'b1;
        end else begin
          if (lives != 2'd0) lives_nx = lives - 2'd1;
          bad_nx = 1'b1;
        end
        show_cnt_nx = SHOW_L;
        state_nx    = SHOW;
      end
      SHOW: begin
        if (tick) begin
          if (show_cnt <= 8'd1) begin
            show_cnt_nx = 8'd0;
            ok_nx       = 1'b0;
            bad_nx      = 1'b0;
            over_nx     = (lives == 2'd0);
            state_nx    = (lives == 2'd0) ? OVER : DRAW;
          end else begin
            show_cnt_nx = show_cnt - 8'd1;
          end
        end
      end
      OVER: begin
        if (start) begin
          over_nx  = 1'b0;
          score_nx = 8'd0;
          lives_nx = START_L;
          state_nx = DRAW;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Strobe-style outputs are derived from the next state so they line up with the state itself.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      lfsr_enable  <= 1'b0;
      round_active <= 1'b0;
      time_left    <= 8'd0;
      score        <= 8'd0;
      lives        <= START_L;
      result_ok    <= 1'b0;
      result_bad   <= 1'b0;
      game_over    <= 1'b0;
      captured     <= 4'd0;
      timeout      <= 1'b0;
      show_cnt     <= 8'd0;
    end else begin
      state        <= state_nx;
      lfsr_enable  <= (state_nx == DRAW);
      round_active <= (state_nx == PLAY);
      time_left    <= time_left_nx;
      score        <= score_nx;
      lives        <= lives_nx;
      result_ok    <= ok_nx;
      result_bad   <= bad_nx;
      game_over    <= over_nx;
      captured     <= captured_nx;
      timeout      <= timeout_nx;
      show_cnt     <= show_cnt_nx;
    end
  end

endmodule

// File: tb/tb_not_not_round_ctrl.sv
// Self-checking bench for not_not_round_ctrl: randomized rounds against a game-level model.
module tb_not_not_round_ctrl;

  localparam int RT = 10;
  localparam int ST = 3;
  localparam int SL = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       answer_valid = 1'b0;
  logic [3:0] answer = 4'd0;
  logic [3:0] expected = 4'd0;
  logic       lfsr_enable, round_active, result_ok, result_bad, game_over;
  logic [7:0] time_left, score;
  logic [1:0] lives;

  int checks = 0;
  int passed = 0;
  int m_score = 0;
  int m_lives = SL;

  not_not_round_ctrl #(.ROUND_TICKS(RT), .SHOW_TICKS(ST), .START_LIVES(SL)) dut (
    .clock(clock), .resetn(resetn), .start(start), .tick(tick),
    .answer_valid(answer_valid), .answer(answer), .expected(expected),
    .lfsr_enable(lfsr_enable), .round_active(round_active), .time_left(time_left),
    .score(score), .lives(lives), .result_ok(result_ok), .result_bad(result_bad),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Round window as the game rules define it, from the score at the start of the round.
  function automatic int window_for(int s);
`ifdef NOT_NOT_SPEEDUP_EN
    int w = RT - 4 * s;
    return (w > RT / 4) ? w : RT / 4;
`else
    return RT;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called just after the edge that entered DRAW; leaves the DUT one cycle into PLAY.
  task automatic enter_play();
    checks++; if (lfsr_enable !== 1'b1) $display("[TB] FAIL draw_lfsr: got %0b want 1", lfsr_enable); else passed++;
    checks++; if (round_active !== 1'b0) $display("[TB] FAIL draw_active: got %0b want 0", round_active); else passed++;
    step();
    checks++; if (lfsr_enable !== 1'b0) $display("[TB] FAIL play_lfsr: got %0b want 0", lfsr_enable); else passed++;
    checks++; if (round_active !== 1'b1) $display("[TB] FAIL play_active: got %0b want 1", round_active); else passed++;
    checks++; if (time_left !== 8'(window_for(m_score)))
      $display("[TB] FAIL window: got %0d want %0d", time_left, window_for(m_score)); else passed++;
  endtask

  // Plays one round from PLAY: n_ticks ticks, then a submit unless the window ran out.
  task automatic play_round(input int n_ticks, input bit correct, input bit coincide);
    int tl = window_for(m_score);
    bit timed_out = 1'b0;
    bit ok;
    expected = 4'($urandom);
    for (int i = 0; i < n_ticks && !timed_out; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (lfsr_enable !== 1'b0) $display("[TB] FAIL start_in_play: lfsr got %0b want 0", lfsr_enable); else passed++;
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      tl--;
      if (tl == 0) timed_out = 1'b1;
      checks++; if (time_left !== 8'(tl)) $display("[TB] FAIL tick_count: got %0d want %0d", time_left, tl); else passed++;
    end
    if (!timed_out) begin
      answer = correct ? expected : expected ^ 4'($urandom_range(1, 15));
      answer_valid = 1'b1;
      tick = coincide;
      step();
      answer_valid = 1'b0;
      tick = 1'b0;
      checks++; if (time_left !== 8'(tl)) $display("[TB] FAIL answer_hold: got %0d want %0d", time_left, tl); else passed++;
    end
    checks++; if (round_active !== 1'b0) $display("[TB] FAIL judge_active: got %0b want 0", round_active); else passed++;
    ok = !timed_out && correct;
    if (ok) m_score = (m_score < 255) ? m_score + 1 : 255;
    else    m_lives = m_lives - 1;
    step();
    checks++; if (result_ok !== ok) $display("[TB] FAIL result_ok: got %0b want %0b", result_ok, ok); else passed++;
    checks++; if (result_bad !== !ok) $display("[TB] FAIL result_bad: got %0b want %0b", result_bad, !ok); else passed++;
    checks++; if (score !== 8'(m_score)) $display("[TB] FAIL score: got %0d want %0d", score, m_score); else passed++;
    checks++; if (lives !== 2'(m_lives)) $display("[TB] FAIL lives: got %0d want %0d", lives, m_lives); else passed++;
    for (int k = 0; k < ST; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        answer_valid = 1'b1;
        answer = 4'($urandom);
        step();
        answer_valid = 1'b0;
        checks++; if (result_ok !== ok) $display("[TB] FAIL show_hold: got %0b want %0b", result_ok, ok); else passed++;
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
    checks++; if (result_ok !== 1'b0 || result_bad !== 1'b0)
      $display("[TB] FAIL show_clear: got ok=%0b bad=%0b want 0/0", result_ok, result_bad); else passed++;
    checks++; if (score !== 8'(m_score)) $display("[TB] FAIL score_after_show: got %0d want %0d", score, m_score); else passed++;
    if (m_lives == 0) begin
      checks++; if (game_over !== 1'b1) $display("[TB] FAIL game_over: got %0b want 1", game_over); else passed++;
    end else begin
      enter_play();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    checks++; if (lfsr_enable !== 1'b0 || round_active !== 1'b0)
      $display("[TB] FAIL reset_strobes: got lfsr=%0b active=%0b want 0/0", lfsr_enable, round_active); else passed++;
    checks++; if (time_left !== 8'd0) $display("[TB] FAIL reset_time: got %0d want 0", time_left); else passed++;
    checks++; if (score !== 8'd0) $display("[TB] FAIL reset_score: got %0d want 0", score); else passed++;
    checks++; if (lives !== 2'(SL)) $display("[TB] FAIL reset_lives: got %0d want %0d", lives, SL); else passed++;
    checks++; if (result_ok !== 1'b0 || result_bad !== 1'b0 || game_over !== 1'b0)
      $display("[TB] FAIL reset_flags: got %0b%0b%0b want 000", result_ok, result_bad, game_over); else passed++;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      answer_valid = 1'(i % 2);
      step();
      checks++; if (lfsr_enable !== 1'b0 || round_active !== 1'b0)
        $display("[TB] FAIL idle_hold: got lfsr=%0b active=%0b want 0/0", lfsr_enable, round_active); else passed++;
    end
    tick = 1'b0;
    answer_valid = 1'b0;
  endtask

  task automatic test_start();
    m_score = 0;
    m_lives = SL;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (score !== 8'd0 || lives !== 2'(SL))
      $display("[TB] FAIL start_load: got score=%0d lives=%0d want 0/%0d", score, lives, SL); else passed++;
    enter_play();
  endtask

  task automatic test_correct();
    play_round(3, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    play_round(window_for(m_score), 1'b1, 1'b0);
  endtask

  task automatic test_coincide();
    play_round(window_for(m_score) - 1, 1'b1, 1'b1);
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 3; r++)
      play_round($urandom_range(0, window_for(m_score) - 2), 1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid_play();
    tick = 1'b1;
    step();
    tick = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (score !== 8'd0 || lives !== 2'(SL) || time_left !== 8'd0)
      $display("[TB] FAIL async_reset_counts: got score=%0d lives=%0d time=%0d want 0/%0d/0", score, lives, time_left, SL); else passed++;
    checks++; if (round_active !== 1'b0 || lfsr_enable !== 1'b0 || result_ok !== 1'b0 || result_bad !== 1'b0 || game_over !== 1'b0)
      $display("[TB] FAIL async_reset_flags: got active=%0b lfsr=%0b ok=%0b bad=%0b over=%0b want all 0",
               round_active, lfsr_enable, result_ok, result_bad, game_over); else passed++;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (lfsr_enable !== 1'b0 || round_active !== 1'b0)
        $display("[TB] FAIL post_reset_idle: got lfsr=%0b active=%0b want 0/0", lfsr_enable, round_active); else passed++;
    end
  endtask

  task automatic test_game_over();
    while (m_lives > 0) play_round($urandom_range(0, window_for(m_score) - 2), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      answer_valid = 1'b1;
      step();
      tick = 1'b0;
      answer_valid = 1'b0;
      checks++; if (game_over !== 1'b1 || lives !== 2'd0 || score !== 8'(m_score) || lfsr_enable !== 1'b0)
        $display("[TB] FAIL over_frozen: got over=%0b lives=%0d score=%0d lfsr=%0b want 1/0/%0d/0",
                 game_over, lives, score, lfsr_enable, m_score); else passed++;
    end
    m_score = 0;
    m_lives = SL;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (game_over !== 1'b0 || score !== 8'd0 || lives !== 2'(SL))
      $display("[TB] FAIL restart: got over=%0b score=%0d lives=%0d want 0/0/%0d", game_over, score, lives, SL); else passed++;
    enter_play();
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 257; r++) play_round(0, 1'b1, 1'b0);
    checks++; if (score !== 8'd255) $display("[TB] FAIL saturation: got %0d want 255", score); else passed++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_correct();
    test_timeout();
    test_coincide();
    test_random_rounds();
    test_reset_mid_play();
    test_start();
    test_game_over();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/not_not_round_ctrl.md
NOT_NOT_ROUND_CTRL -- requirements
Module: not_not_round_ctrl

Interface
REQ-001 The block SHALL have parameter ROUND_TICKS, default 200, meaning the answer window in tick strobes (legal 4..255).
REQ-002 The block SHALL have parameter SHOW_TICKS, default 50, meaning the result display time in tick strobes (legal 1..255).
REQ-003 The block SHALL have parameter START_LIVES, default 3, meaning the lives at game start (legal 1..3).
REQ-004 The block SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port start  in  1  begin/restart request, sampled each cycle.
REQ-007 The block SHALL have port tick  in  1  one-cycle timebase strobe.
REQ-008 The block SHALL have port answer_valid  in  1  one-cycle player submit strobe.
REQ-009 The block SHALL have port answer  in  4  player colour pattern, qualified by answer_valid.
REQ-010 The block SHALL have port expected  in  4  correct pattern from the puzzle datapath.
REQ-011 The block SHALL have port lfsr_enable  out  1  advance strobe to the puzzle LFSRs.
REQ-012 The block SHALL have port round_active  out  1  high while an answer is accepted.
REQ-013 The block SHALL have port time_left  out  8  remaining ticks in the current round.
REQ-014 The block SHALL have port score  out  8  correct answers this game, saturating.
REQ-015 The block SHALL have port lives  out  2  remaining lives.
REQ-016 The block SHALL have ports result_ok and result_bad  out  1 each  verdict of the last round, held during display.
REQ-017 The block SHALL have port game_over  out  1  high when lives are exhausted.

Function
REQ-018 The FSM SHALL have states IDLE, DRAW, PLAY, JUDGE, SHOW, OVER; all outputs registered.
REQ-019 In IDLE, start=1 SHALL load score=0, lives=START_LIVES and enter DRAW next cycle; start SHALL be ignored in DRAW, PLAY, JUDGE, SHOW.
REQ-020 DRAW SHALL last exactly one cycle with lfsr_enable=1, load time_left with the round window, then enter PLAY; lfsr_enable SHALL be 0 in every other state.
REQ-021 In PLAY, round_active=1; each tick SHALL decrement time_left by 1.
REQ-022 In PLAY, answer_valid=1 SHALL capture answer and enter JUDGE; answer_valid outside PLAY SHALL be ignored.
REQ-023 In PLAY, a tick with time_left=1 and no answer_valid SHALL set time_left=0, flag timeout and enter JUDGE; if answer_valid coincides with that tick, the answer SHALL win and time_left SHALL hold.
REQ-024 JUDGE SHALL last one cycle: correct iff no timeout and captured answer equals expected (expected stable since lfsr_enable is low).
REQ-025 Correct SHALL increment score, saturating at 255, and set result_ok=1; wrong or timeout SHALL decrement lives and set result_bad=1; then enter SHOW with display counter = SHOW_TICKS.
REQ-026 SHOW SHALL decrement the display counter per tick; at zero it SHALL clear result_ok/result_bad and enter OVER if lives=0, else DRAW.
REQ-027 OVER SHALL hold game_over=1, score and lives frozen; start=1 SHALL clear game_over, reload score=0, lives=START_LIVES and enter DRAW.
REQ-028 tick SHALL be ignored in IDLE, DRAW, JUDGE, OVER.

Reset
REQ-029 resetn=0 SHALL immediately force IDLE, lfsr_enable=0, round_active=0, time_left=0, score=0, lives=START_LIVES, result_ok=0, result_bad=0, game_over=0, from any state including mid-round.
REQ-030 Leaving reset, the block SHALL stay in IDLE until start=1.

Configuration
REQ-031 With NOT_NOT_SPEEDUP_EN defined, the round window loaded in DRAW SHALL be max(ROUND_TICKS - 4*score, ROUND_TICKS/4) (integer division); without it, the window SHALL always be ROUND_TICKS.

Verification
REQ-032 Reset then start, ROUND_TICKS=10 -> one-cycle lfsr_enable pulse, time_left=10, round_active=1.
REQ-033 answer=expected=4'b0101 after 3 ticks -> result_ok=1 for SHOW_TICKS ticks, score=1, lives=3, new DRAW.
REQ-034 No answer for 10 ticks -> time_left=0, result_bad=1, lives 3->2; answer_valid coinciding with tick 10 (correct) -> result_ok=1, time_left=1.
REQ-035 Three wrong rounds -> lives=0, game_over=1; start -> score=0, lives=3, DRAW.
REQ-036 resetn low mid-PLAY with score=5 -> all outputs at reset values same edge-independent; start ignored in PLAY produces no extra lfsr_enable.
REQ-037 With NOT_NOT_SPEEDUP_EN, ROUND_TICKS=200, score=10 -> time_left loaded 160; score=60 -> loaded 50.
